// File: rtl/stepper_pkg.sv
// Shared phase definitions for the stepper drive and decoder: phase codes,
// coil patterns and the neighbour relations of the full-step sequence.
package stepper_pkg;

  typedef enum logic [2:0] {
    PH_DIS   = 3'b000,
    PH_AB    = 3'b001,
    PH_BC    = 3'b011,
    PH_CD    = 3'b010,
    PH_DA    = 3'b110,
    PH_FAULT = 3'b111
  } phase_e;

  // Coil patterns as {A,B,C,D}
  localparam logic [3:0] PAT_DIS = 4'b0000;
  localparam logic [3:0] PAT_AB  = 4'b1100;
  localparam logic [3:0] PAT_BC  = 4'b0110;
  localparam logic [3:0] PAT_CD  = 4'b0011;
  localparam logic [3:0] PAT_DA  = 4'b1001;

  localparam logic [9:0] STEPS_MAX = 10'd1023;

  // Any pattern that is not disabled or a legal pair decodes to FAULT.
  function automatic phase_e pat_to_phase(input logic [3:0] pat);
    phase_e ph;
    case (pat)
      PAT_DIS: ph = PH_DIS;
      PAT_AB:  ph = PH_AB;
      PAT_BC:  ph = PH_BC;
      PAT_CD:  ph = PH_CD;
      PAT_DA:  ph = PH_DA;
      default: ph = PH_FAULT;
    endcase
    return ph;
  endfunction

  function automatic phase_e phase_fwd(input phase_e ph);
    phase_e nxt;
    case (ph)
      PH_AB:   nxt = PH_BC;
      PH_BC:   nxt = PH_CD;
      PH_CD:   nxt = PH_DA;
      PH_DA:   nxt = PH_AB;
      default: nxt = ph;
    endcase
    return nxt;
  endfunction

  function automatic phase_e phase_bwd(input phase_e ph);
    phase_e nxt;
    case (ph)
      PH_AB:   nxt = PH_DA;
      PH_BC:   nxt = PH_AB;
      PH_CD:   nxt = PH_BC;
      PH_DA:   nxt = PH_CD;
      default: nxt = ph;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/stepper_pattern_filter.sv
// Registers the coil pattern every cycle and strobes o_accept once a pattern
// has been held for STABLE_CYCLES consecutive samples.
module stepper_pattern_filter #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_pat,
  output logic [3:0] o_pat,
  output logic       o_accept
);

  localparam logic [3:0] LP_LOAD = 4'(STABLE_CYCLES);

  logic [3:0] r_pat;
  logic [3:0] r_cnt;

  // Down-counter reloads on every change; terminal count 1 fires exactly once
  // per stable run, then the counter parks at zero until the pattern changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat <= '0;
      r_cnt <= '0;
    end else begin
      r_pat <= i_pat;
      if (i_pat != r_pat) begin
        r_cnt <= LP_LOAD;
      end else if (r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign o_pat    = r_pat;
  assign o_accept = (r_cnt == 4'd1);

endmodule

// File: rtl/stepper_phase_decoder.sv
// Decodes four coil duty inputs into a full-step phase, tracks direction,
// signed position, a step count against a loaded target, and a sticky fault.
//
// state    | meaning
// PH_DIS   | all coils off, no phase held
// PH_AB    | coils A+B energised
// PH_BC    | coils B+C energised
// PH_CD    | coils C+D energised
// PH_DA    | coils D+A energised
// PH_FAULT | illegal sequence seen, waits for clr_fault
module stepper_phase_decoder #(
  parameter logic [7:0] THRESH        = 8'd1,
  parameter int         STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  inA,
  input  logic [7:0]  inB,
  input  logic [7:0]  inC,
  input  logic [7:0]  inD,
  input  logic        en,
  input  logic [9:0]  i_Cycles,
  input  logic        clr_fault,
  output logic [2:0]  o_state,
  output logic        o_dir,
  output logic        o_step,
  output logic [15:0] o_position,
  output logic [9:0]  o_steps,
  output logic        o_done,
  output logic        o_fault
);

  import stepper_pkg::*;

  logic [3:0] w_pat;
  logic [3:0] w_filt_pat;
  logic       w_accept;
  phase_e     w_acc_ph;
  phase_e     w_state_nxt;
  logic       w_step_nxt;
  logic       w_dir_nxt;

  phase_e      r_state;
  logic        r_dir;
  logic        r_step;
  logic [15:0] r_pos;
  logic [9:0]  r_steps;
  logic [9:0]  r_target;

  assign w_pat = {inA >= THRESH, inB >= THRESH, inC >= THRESH, inD >= THRESH};

  stepper_pattern_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk      (clk),
    .rst      (rst),
    .i_pat    (w_pat),
    .o_pat    (w_filt_pat),
    .o_accept (w_accept)
  );

  assign w_acc_ph = pat_to_phase(w_filt_pat);

  // A fault-causing acceptance that coincides with clr_fault lands in DIS;
  // the filter will not re-strobe until a fresh stable run.
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = 1'b0;
    w_dir_nxt   = r_dir;
    if (r_state == PH_FAULT) begin
      if (clr_fault) begin
        w_state_nxt = PH_DIS;
      end
    end else if (w_accept && (w_acc_ph != r_state)) begin
      if (w_acc_ph == PH_FAULT) begin
        w_state_nxt = clr_fault ? PH_DIS : PH_FAULT;
      end else if ((w_acc_ph == PH_DIS) || (r_state == PH_DIS)) begin
        w_state_nxt = w_acc_ph;
      end else if (w_acc_ph == phase_fwd(r_state)) begin
        w_state_nxt = w_acc_ph;
        w_step_nxt  = 1'b1;
        w_dir_nxt   = 1'b1;
      end else if (w_acc_ph == phase_bwd(r_state)) begin
        w_state_nxt = w_acc_ph;
        w_step_nxt  = 1'b1;
        w_dir_nxt   = 1'b0;
      end else begin
        w_state_nxt = clr_fault ? PH_DIS : PH_FAULT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= PH_DIS;
      r_dir    <= 1'b0;
      r_step   <= 1'b0;
      r_pos    <= '0;
      r_steps  <= '0;
      r_target <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      r_step  <= w_step_nxt;
      if (w_step_nxt) begin
        r_pos <= w_dir_nxt ? (r_pos + 16'd1) : (r_pos - 16'd1);
      end
      if (en) begin
        r_target <= i_Cycles;
        r_steps  <= '0;
      end else if (w_step_nxt && (r_steps != STEPS_MAX)) begin
        r_steps <= r_steps + 10'd1;
      end
    end
  end

  assign o_state    = r_state;
  assign o_dir      = r_dir;
  assign o_step     = r_step;
  assign o_position = r_pos;
  assign o_steps    = r_steps;
  assign o_done     = (r_steps == r_target);
  assign o_fault    = (r_state == PH_FAULT);

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Bench for stepper_phase_decoder: run-length/index-arithmetic reference model
// compared every cycle, directed scenarios with literal expectations, random traffic.
module tb_stepper_phase_decoder;

  localparam logic [7:0] TB_THRESH = 8'd100;
  localparam int         SC        = 4;

  logic        clk = 1'b0;
  logic        rst, en, clr_fault;
  logic [7:0]  inA, inB, inC, inD;
  logic [9:0]  i_Cycles;

  logic [2:0]  o_state, f_o_state;
  logic        o_dir, o_step, o_done, o_fault;
  logic        f_o_dir, f_o_step, f_o_done, f_o_fault;
  logic [15:0] o_position, f_o_position;
  logic [9:0]  o_steps, f_o_steps;

  always #5 clk = ~clk;

  stepper_phase_decoder #(.THRESH(TB_THRESH), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .inA(inA), .inB(inB), .inC(inC), .inD(inD),
    .en(en), .i_Cycles(i_Cycles), .clr_fault(clr_fault),
    .o_state(o_state), .o_dir(o_dir), .o_step(o_step), .o_position(o_position),
    .o_steps(o_steps), .o_done(o_done), .o_fault(o_fault));

  // Single-sample filter instance, used to reach position wrap quickly.
  stepper_phase_decoder #(.THRESH(TB_THRESH), .STABLE_CYCLES(1)) dut_fast (
    .clk(clk), .rst(rst), .inA(inA), .inB(inB), .inC(inC), .inD(inD),
    .en(en), .i_Cycles(i_Cycles), .clr_fault(clr_fault),
    .o_state(f_o_state), .o_dir(f_o_dir), .o_step(f_o_step), .o_position(f_o_position),
    .o_steps(f_o_steps), .o_done(f_o_done), .o_fault(f_o_fault));

  int n_checks, n_errors;
  int pulses, f_pulses;

  // Reference model: phase -1 = disabled, 0..3 = AB,BC,CD,DA, 4 = fault
  logic [3:0] m_run_pat;
  int         m_run_len, m_phase, m_pos, m_steps, m_target;
  bit         m_dir, m_step;

  function automatic logic [3:0] seq_pat(input int i);
    case (i % 4)
      0: return 4'b1100;
      1: return 4'b0110;
      2: return 4'b0011;
      default: return 4'b1001;
    endcase
  endfunction

  function automatic int pat_idx(input logic [3:0] p);
    case (p)
      4'b0000: return -1;
      4'b1100: return 0;
      4'b0110: return 1;
      4'b0011: return 2;
      4'b1001: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int phase_code(input int ph);
    case (ph)
      0: return 1;
      1: return 3;
      2: return 2;
      3: return 6;
      4: return 7;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] duty(input logic act);
    int r;
    r = int'($urandom_range(3, 0));
    if (act) return (r == 0) ? TB_THRESH : 8'($urandom_range(255, int'(TB_THRESH)));
    return (r == 0) ? (TB_THRESH - 8'd1) : 8'($urandom_range(int'(TB_THRESH) - 1, 0));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [3:0] s;
    int idx;
    bit acc;
    s = {inA >= TB_THRESH, inB >= TB_THRESH, inC >= TB_THRESH, inD >= TB_THRESH};
    m_step = 1'b0;
    if (rst) begin
      m_run_pat = 4'b0000; m_run_len = 0; m_phase = -1; m_dir = 1'b0;
      m_pos = 0; m_steps = 0; m_target = 0;
      return;
    end
    acc = (m_run_len == SC);
    idx = pat_idx(m_run_pat);
    if (m_phase == 4) begin
      if (clr_fault) m_phase = -1;
    end else if (acc && idx != m_phase) begin
      if (idx == -1) m_phase = -1;
      else if (idx != 4 && m_phase == -1) m_phase = idx;
      else if (idx != 4 && idx == (m_phase + 1) % 4) begin
        m_phase = idx; m_step = 1'b1; m_dir = 1'b1; m_pos++;
      end else if (idx != 4 && idx == (m_phase + 3) % 4) begin
        m_phase = idx; m_step = 1'b1; m_dir = 1'b0; m_pos--;
      end else m_phase = clr_fault ? -1 : 4;
    end
    if (en) begin
      m_steps = 0; m_target = int'(i_Cycles);
    end else if (m_step && m_steps < 1023) m_steps++;
    if (s == m_run_pat) begin
      if (m_run_len < 100) m_run_len++;
    end else begin
      m_run_pat = s; m_run_len = 1;
    end
  endtask

  task automatic compare_all();
    chk("o_state",    int'(o_state),    phase_code(m_phase));
    chk("o_step",     int'(o_step),     int'(m_step));
    chk("o_dir",      int'(o_dir),      int'(m_dir));
    chk("o_position", int'(o_position), m_pos & 32'hFFFF);
    chk("o_steps",    int'(o_steps),    m_steps);
    chk("o_done",     int'(o_done),     int'(m_steps == m_target));
    chk("o_fault",    int'(o_fault),    int'(m_phase == 4));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (o_step)   pulses++;
    if (f_o_step) f_pulses++;
    compare_all();
  endtask

  task automatic drive(input logic [3:0] p);
    inA = duty(p[3]); inB = duty(p[2]); inC = duty(p[1]); inD = duty(p[0]);
  endtask

  task automatic hold(input logic [3:0] p, input int n);
    repeat (n) begin
      drive(p);
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hold(4'b0000, 1);
    rst = 1'b0;
  endtask

  initial begin
    int base, ci, len, r;
    logic [3:0] p;
    n_checks = 0; n_errors = 0; pulses = 0; f_pulses = 0;
    rst = 1'b1; en = 1'b0; clr_fault = 1'b0; i_Cycles = '0;
    hold(4'b0000, 2);
    chk("reset_state", int'(o_state), 0);
    chk("reset_done",  int'(o_done), 1);
    chk("reset_pos",   int'(o_position), 0);
    rst = 1'b0;

    // forward AB,BC,CD,DA,AB
    base = pulses;
    for (int i = 0; i < 5; i++) hold(seq_pat(i), 300);
    chk("fwd_pulses", pulses - base, 4);
    chk("fwd_dir",    int'(o_dir), 1);
    chk("fwd_pos",    int'($signed(o_position)), 4);
    chk("fwd_state",  int'(o_state), 1);

    // reverse AB,DA,CD,BC
    do_reset();
    base = pulses;
    for (int i = 4; i > 0; i--) hold(seq_pat(i), 300);
    chk("rev_pulses", pulses - base, 3);
    chk("rev_dir",    int'(o_dir), 0);
    chk("rev_pos",    int'($signed(o_position)), -3);

    // glitch filtering and exact acceptance latency
    do_reset();
    hold(4'b1100, 20);
    base = pulses;
    hold(4'b0110, 3);
    hold(4'b1100, 20);
    chk("glitch_pulses", pulses - base, 0);
    chk("glitch_state",  int'(o_state), 1);
    hold(4'b0110, 4);
    chk("lat_before", int'(o_step), 0);
    hold(4'b0110, 1);
    chk("lat_at_k4",  int'(o_step), 1);
    chk("lat_state",  int'(o_state), 3);
    hold(4'b0110, 1);
    chk("lat_after",  int'(o_step), 0);

    // step target and o_done
    do_reset();
    hold(4'b1100, 10);
    en = 1'b1; i_Cycles = 10'd2;
    hold(4'b1100, 1);
    en = 1'b0;
    chk("tgt_steps0", int'(o_steps), 0);
    chk("tgt_done0",  int'(o_done), 0);
    hold(4'b0110, 10);
    chk("tgt_done1",  int'(o_done), 0);
    hold(4'b0011, 10);
    chk("tgt_done2",  int'(o_done), 1);
    hold(4'b1001, 10);
    chk("tgt_done3",  int'(o_done), 0);
    chk("tgt_steps3", int'(o_steps), 3);

    // opposite pair fault, clear together with en
    do_reset();
    hold(4'b1100, 10);
    hold(4'b0011, 10);
    chk("opp_state", int'(o_state), 7);
    chk("opp_fault", int'(o_fault), 1);
    chk("opp_pos",   int'(o_position), 0);
    clr_fault = 1'b1; en = 1'b1; i_Cycles = 10'd5;
    hold(4'b0011, 1);
    clr_fault = 1'b0; en = 1'b0;
    chk("clr_state", int'(o_state), 0);
    chk("clr_fault", int'(o_fault), 0);
    chk("clr_done",  int'(o_done), 0);
    hold(4'b0011, 10);
    chk("clr_hold_state", int'(o_state), 0);

    // single coil fault with frozen position
    hold(4'b1100, 10);
    hold(4'b0110, 10);
    hold(4'b1000, 10);
    chk("coil_state", int'(o_state), 7);
    hold(4'b0011, 10);
    chk("coil_pos", int'(o_position), 1);
    clr_fault = 1'b1;
    hold(4'b0011, 1);
    clr_fault = 1'b0;
    chk("coil_clr", int'(o_state), 0);

    // clear coinciding with a fault-causing acceptance
    hold(4'b1100, 10);
    hold(4'b0011, 4);
    clr_fault = 1'b1;
    hold(4'b0011, 1);
    clr_fault = 1'b0;
    chk("coinc_state", int'(o_state), 0);
    chk("coinc_fault", int'(o_fault), 0);
    hold(4'b0011, 10);
    chk("coinc_hold",  int'(o_state), 0);

    // position wrap on the single-sample instance
    do_reset();
    base = f_pulses;
    hold(4'b1100, 1);
    for (int i = 1; i <= 32767; i++) hold(seq_pat(i), 1);
    hold(seq_pat(32767), 1);
    chk("wrap_pulses", f_pulses - base, 32767);
    chk("wrap_pos_max", int'($signed(f_o_position)), 32767);
    chk("wrap_steps_sat", int'(f_o_steps), 1023);
    hold(seq_pat(0), 2);
    chk("wrap_pos_min", int'($signed(f_o_position)), -32768);
    chk("wrap_dir",     int'(f_o_dir), 1);

    // reset in the middle of qualifying a new pattern
    hold(4'b1100, 10);
    hold(4'b0110, 2);
    rst = 1'b1;
    hold(4'b0110, 1);
    rst = 1'b0;
    chk("rst_state", int'(o_state), 0);
    chk("rst_pos",   int'(o_position), 0);
    chk("rst_step",  int'(o_step), 0);
    chk("rst_done",  int'(o_done), 1);
    chk("rst_dir",   int'(o_dir), 0);
    hold(4'b0110, 4);
    chk("requal_wait", int'(o_state), 0);
    hold(4'b0110, 1);
    chk("requal_done", int'(o_state), 3);
    chk("requal_step", int'(o_step), 0);

    // random traffic against the model
    ci = 0;
    repeat (400) begin
      r = int'($urandom_range(99, 0));
      if (r < 60) begin
        ci = (ci + (($urandom_range(1, 0) == 1) ? 1 : 3)) % 4;
        p = seq_pat(ci);
      end else if (r < 70) p = 4'b0000;
      else if (r < 80) p = 4'($urandom_range(15, 0));
      else p = seq_pat(int'($urandom_range(3, 0)));
      len = int'($urandom_range(8, 1));
      repeat (len) begin
        en        = ($urandom_range(30, 0) == 0);
        i_Cycles  = 10'($urandom_range(4, 0));
        clr_fault = ($urandom_range(20, 0) == 0);
        rst       = ($urandom_range(300, 0) == 0);
        hold(p, 1);
      end
    end
    rst = 1'b0; en = 1'b0; clr_fault = 1'b0;
    hold(4'b0000, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stepper_phase_decoder.md
STEPPER_PHASE_DECODER -- requirements
Module: stepper_phase_decoder

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset: clk and rst.
REQ-002 Parameter THRESH, default 8'd1: a coil is active when its duty input is >= THRESH.
REQ-003 Parameter STABLE_CYCLES, default 4, range 1..15: consecutive identical samples required before a coil pattern is accepted.
REQ-004 clk  input  1  clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 inA, inB, inC, inD  input  8 each  coil duty values from the drive.
REQ-007 en  input  1  load i_Cycles as the step target and clear o_steps.
REQ-008 i_Cycles  input  10  step target, sampled only while en=1.
REQ-009 clr_fault  input  1  clear the sticky fault.
REQ-010 o_state  output  3  decoded phase: dis 000, AB 001, BC 011, CD 010, DA 110, FAULT 111.
REQ-011 o_dir  output  1  direction of the last accepted step: 1 = forward (AB->BC->CD->DA->AB).
REQ-012 o_step  output  1  one-cycle pulse per accepted step.
REQ-013 o_position  output  16  signed step position.
REQ-014 o_steps  output  10  steps counted since the last en.
REQ-015 o_done  output  1  high while o_steps == loaded target.
REQ-016 o_fault  output  1  sticky illegal-sequence flag.

Function
REQ-017 SHALL register the 4-bit active pattern {A,B,C,D} every cycle; a stability counter restarts on any change in the registered pattern.
REQ-018 Pattern accepted when held for STABLE_CYCLES consecutive samples and different from the current decoded pattern; evaluated once per acceptance.
REQ-019 Latency: pattern first presented before edge k -> o_state/o_step/o_position update at edge k+STABLE_CYCLES; o_step high for exactly that one cycle.
REQ-020 Valid patterns: 0000 -> dis; 1100 -> AB; 0110 -> BC; 0011 -> CD; 1001 -> DA; every other pattern is illegal.
REQ-021 dis -> any valid pair: enter that state, no step, o_position unchanged.
REQ-022 Pair -> forward neighbour: o_step=1, o_dir=1, o_position +1.
REQ-023 Pair -> backward neighbour: o_step=1, o_dir=0, o_position -1.
REQ-024 Pair -> dis: enter dis, no step, no fault.
REQ-025 Pair -> opposite pair (AB<->CD, BC<->DA) or any illegal pattern accepted: enter FAULT, o_fault=1, no step.
REQ-026 FAULT: ignore accepted patterns and do not change position/steps; clr_fault=1 -> dis at the next edge, o_fault=0.
REQ-027 o_position wraps two's-complement (32767+1 -> -32768).
REQ-028 o_steps increments on every o_step and saturates at 1023.
REQ-029 en=1: target <= i_Cycles, o_steps <= 0 at the same edge; a step accepted in that cycle is not counted; o_position unaffected.
REQ-030 en and clr_fault in the same cycle: both take effect.
REQ-031 clr_fault coinciding with a faulting acceptance: clear wins; the pattern is re-evaluated only after a new stable run.

Reset
REQ-032 rst=1 at an edge: o_state=dis, o_dir=0, o_step=0, o_position=0, o_steps=0, target=0, o_done=1, o_fault=0, pattern register and stability counter cleared.
REQ-033 Reset mid-step: a pending, unaccepted pattern is discarded and must re-qualify for a full STABLE_CYCLES after rst falls.

Structure
REQ-034 Phase state codes (REQ-010) SHALL live in shared package stepper_pkg, used by the drive and this decoder.
REQ-035 Single sub-module stepper_pattern_filter (pattern register + stability counter + accept strobe); state machine and counters in the top.

Verification
REQ-036 Reset, then AB,BC,CD,DA,AB each held 300 cycles -> 4 o_step pulses, o_dir=1, o_position=4, o_state=001.
REQ-037 Reverse AB,DA,CD,BC (300 cycles each) -> 3 pulses, o_dir=0, o_position=-3.
REQ-038 Glitch BC for 3 cycles inside AB (STABLE_CYCLES=4) -> no o_step; BC held 4 cycles -> o_step exactly at edge k+4.
REQ-039 en with i_Cycles=2, three forward steps -> o_done high after 2nd step and low after 3rd; o_steps=3.
REQ-040 AB then CD, and separately AB then single-coil 1000 -> o_fault=1, o_state=111, position frozen; clr_fault -> o_state=000, o_fault=0.
REQ-041 Preload o_position to 32767 via steps, one forward step -> -32768; rst mid-hold of a new pattern -> all outputs at REQ-032 values, no step.
